// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle, DATA_W steps
// per operation. MTHI/MTLO write rs_data directly into HI/LO while idle.
// Optional feature macro: MDU_SIGNED_EN -- when defined, op[0]=0 selects signed
// MULT/DIV; when undefined every operation is unsigned and op[0] is ignored.
module mul_div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mthi,
  input  logic              mtlo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  // MUL: {upper partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [2*DATA_W-1:0] acc_q, acc_d;
  // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [DATA_W-1:0]   b_q, b_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                div_zero_q, div_zero_d;

  // Operand sign handling at launch
  logic              signed_op;
  logic              neg_a, neg_b;
  logic [DATA_W-1:0] abs_a, abs_b;

`ifdef MDU_SIGNED_EN
  assign signed_op = ~op[0];
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign signed_op  = 1'b0;
`endif

  assign neg_a = signed_op & rs_data[DATA_W-1];
  assign neg_b = signed_op & rt_data[DATA_W-1];
  assign abs_a = neg_a ? (~rs_data + 1'b1) : rs_data;
  assign abs_b = neg_b ? (~rt_data + 1'b1) : rt_data;

  // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set
  logic [DATA_W-1:0]   mul_addend;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [2*DATA_W-1:0] mul_res;

  assign mul_addend = acc_q[0] ? b_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[DATA_W-1:1]};
  assign mul_res    = neg_res_q ? (~mul_next + 1'b1) : mul_next;

  // Restoring divide step; a zero divisor naturally yields quotient all-ones, remainder = dividend
  logic [DATA_W:0]   div_shift, div_diff;
  logic              div_ge;
  logic [DATA_W-1:0] div_rem, div_quo;
  logic [DATA_W-1:0] quo_res, rem_res;

  assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[DATA_W];
  assign div_rem   = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
  assign div_quo   = {acc_q[DATA_W-2:0], div_ge};
  assign quo_res   = dz_q ? '1 : (neg_res_q ? (~div_quo + 1'b1) : div_quo);
  assign rem_res   = neg_rem_q ? (~div_rem + 1'b1) : div_rem;

  logic last;
  assign last = (cnt_q == CntW'(DATA_W - 1));

  // Next-state: launch, iterate, write back on the final step
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = op[1] ? StDiv : StMul;
          cnt_d     = '0;
          acc_d     = {{DATA_W{1'b0}}, (op[1] ? abs_a : abs_b)};
          b_d       = op[1] ? abs_b : abs_a;
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          dz_d      = (rt_data == '0);
        end else begin
          // Start wins over same-cycle MTHI/MTLO
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d      = StIdle;
          cnt_d        = '0;
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
        end
      end
      StDiv: begin
        acc_d = {div_rem, div_quo};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d    = StIdle;
          cnt_d      = '0;
          hi_d       = rem_res;
          lo_d       = quo_res;
          done_d     = 1'b1;
          div_zero_d = dz_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: reference model feeds a scoreboard queue,
// results are popped and compared when done pulses.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];

  mul_div_unit #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // Reference model using native arithmetic
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t                  e;
    logic                  sgn;
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0]        up;
    logic signed [W-1:0]   sa, sbv;
`ifdef MDU_SIGNED_EN
    sgn = ~o[0];
`else
    sgn = 1'b0;
`endif
    e.dz = 1'b0;
    sa   = a;
    sbv  = b;
    if (!o[1]) begin
      if (sgn) begin
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        {e.hi, e.lo} = sp;
      end else begin
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        {e.hi, e.lo} = up;
      end
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000;
        e.hi = '0;
      end else begin
        e.lo = sa / sbv;
        e.hi = sa % sbv;
      end
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic with_mt);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    mthi    = with_mt;
    mtlo    = with_mt;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
  endtask

  // Launch one operation, watch busy/hold behaviour, compare against the scoreboard
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit disturb, input bit with_mt);
    exp_t         e;
    logic [W-1:0] hi0, lo0;
    int           cyc;
    bit           got;
    hi0 = hi;
    lo0 = lo;
    sb_q.push_back(model(o, a, b));
    launch(o, a, b, with_mt);
    cyc = 0;
    got = 0;
    while (cyc < 100) begin
      if (done) begin
        got = 1;
        break;
      end
      checks++;
      if (busy !== 1'b1 || hi !== hi0 || lo !== lo0) begin
        failures++;
        $display("FAIL %s_hold cyc=%0d: busy=%b hi=%h lo=%h, required busy=1 hi=%h lo=%h",
                 name, cyc, busy, hi, lo, hi0, lo0);
      end
      if (disturb && cyc == 5) begin
        start   = 1'b1;
        op      = ~o;
        rs_data = ~a;
        rt_data = b + 1;
        mthi    = 1'b1;
        mtlo    = 1'b1;
      end else if (disturb && cyc == 6) begin
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", name, cyc);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      if (cyc !== 32 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_latency: busy_cycles=%0d busy=%b, required 32 and busy=0", name, cyc,
                 busy);
      end
      checks++;
      if (hi !== e.hi || lo !== e.lo) begin
        failures++;
        $display("FAIL %s_result: hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, e.hi, e.lo);
      end
      checks++;
      if (div_zero !== e.dz) begin
        failures++;
        $display("FAIL %s_div_zero: div_zero=%b, required %b", name, div_zero, e.dz);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0 || hi !== e.hi) begin
        failures++;
        $display("FAIL %s_after: done=%b div_zero=%b busy=%b hi=%h, required 0 0 0 hi=%h",
                 name, done, div_zero, busy, hi, e.hi);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b div_zero=%b, required all zero",
               hi, lo, busy, done, div_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      failures++;
      $display("FAIL multu_max_const: hi=%h lo=%h, required fffffffe 00000001", hi, lo);
    end
    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0);
    run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op("mult_neg_neg", 2'b00, 32'hFFFF_FF00, 32'hFFFF_FFF0, 0, 0);
    run_op("multu_zero", 2'b01, 32'h0000_0000, 32'h1234_5678, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_op("mul_rand", {1'b0, 1'($urandom_range(0, 1))}, $urandom, $urandom, 0, 0);
    end
  endtask

  task automatic test_div();
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0, 0);
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      failures++;
      $display("FAIL divu_100_7_const: hi=%h lo=%h, required 2 and 14", hi, lo);
    end
    run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("divu_min_max", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("div_7_neg2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0);
    run_op("divu_small_big", 2'b11, 32'h0000_0005, 32'h0000_0009, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_op("div_rand", {1'b1, 1'($urandom_range(0, 1))}, $urandom, $urandom_range(1, 65535), 0,
             0);
    end
  endtask

  task automatic test_div_zero();
    run_op("divu_zero", 2'b11, 32'h1234_5678, 32'h0000_0000, 0, 0);
    run_op("div_zero_pos", 2'b10, 32'h0000_4321, 32'h0000_0000, 0, 0);
  endtask

  task automatic test_mthi_mtlo();
    bit saw_done;
    saw_done = 0;
    @(negedge clk);
    rs_data = 32'hAAAA_0000; mthi = 1'b1;
    @(negedge clk);
    saw_done |= done;
    mthi = 1'b0;
    checks++;
    if (hi !== 32'hAAAA_0000) begin
      failures++;
      $display("FAIL mthi: hi=%h, required aaaa0000", hi);
    end
    rs_data = 32'h0000_BBBB; mtlo = 1'b1;
    @(negedge clk);
    saw_done |= done;
    mtlo = 1'b0;
    checks++;
    if (lo !== 32'h0000_BBBB || hi !== 32'hAAAA_0000) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h, required aaaa0000 0000bbbb", hi, lo);
    end
    rs_data = 32'h5555_1234; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    saw_done |= done;
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'h5555_1234 || lo !== 32'h5555_1234) begin
      failures++;
      $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required 55551234 both", hi, lo);
    end
    checks++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mt_no_done: saw_done=%b busy=%b, required 0 0", saw_done, busy);
    end
  endtask

  task automatic test_busy_ignore();
    // start with same-cycle mthi/mtlo; then mid-op start/mthi/mtlo and operand changes
    run_op("busy_ignore", 2'b01, 32'h0F0F_0F0F, 32'h0000_0010, 1, 1);
    run_op("busy_ignore_div", 2'b11, 32'hDEAD_BEEF, 32'h0000_0100, 1, 1);
  endtask

  task automatic test_reset_mid();
    bit saw;
    saw = 0;
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 2'b01; rs_data = 32'h3; rt_data = 32'h5;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h done=%b, required 0 0 0 0", busy, hi, lo,
               done);
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      saw |= done | busy;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_quiet: done_or_busy=%b, required 0", saw);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_op("b2b", 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) == 0 ? 32'h0 :
             $urandom, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
